div_iter_unit: RTL and testbench

Iterative radix-2 divider for the RV64 execute stage. It replaces the combinational divide path feeding the ALU result mux. It accepts one DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW operation at a time, computes it over multiple cycles, and returns a 64-bit result with a single-cycle `done` pulse. While the unit is busy, the execute stage holds its operands and stalls the pipeline.

---
 rtl/div_iter_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_div_iter_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - iterative radix-2 restoring divider for RV64M DIV/REM ops

package div_iter_pkg;

  typedef logic [63:0] word_t;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_SLL   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_MUL   = 5'd10,
    ALU_DIV   = 5'd16,
    ALU_DIVU  = 5'd17,
    ALU_REM   = 5'd18,
    ALU_REMU  = 5'd19,
    ALU_DIVW  = 5'd20,
    ALU_DIVUW = 5'd21,
    ALU_REMW  = 5'd22,
    ALU_REMUW = 5'd23
  } alufunc_t;

endpackage

module div_iter_unit
  import div_iter_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     valid_in,
  input  alufunc_t alufunc,
  input  word_t    src1,
  input  word_t    src2,
  output logic     ready,
  output logic     done,
  output word_t    result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam word_t MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic [1:0] r_state;
  logic [5:0] r_cnt;
  word_t      r_rem;
  word_t      r_quo;
  word_t      r_div;
  logic       r_neg_q;
  logic       r_neg_r;
  logic       r_is_rem;
  logic       r_is_w;
  word_t      r_result;

  logic        w_is_divop;
  logic        w_is_signed;
  logic        w_is_rem;
  logic        w_is_w;
  logic [31:0] w_a32;
  logic [31:0] w_b32;
  logic        w_a_neg;
  logic        w_b_neg;
  word_t       w_a_ext;
  word_t       w_b_ext;
  word_t       w_a_sx;
  word_t       w_a_abs;
  word_t       w_b_abs;
  logic        w_b_zero;
  logic        w_ovf;
  logic        w_special;
  word_t       w_spec_res;
  logic        w_accept;
  logic [64:0] w_rem_sh;
  logic [64:0] w_diff;
  logic        w_ge;
  word_t       w_rem_next;
  word_t       w_quo_next;
  logic [5:0]  w_last_cnt;
  word_t       w_q_raw;
  word_t       w_q_fix;
  word_t       w_r_fix;
  word_t       w_sel;
  word_t       w_fix_res;

  // Classify the requested operation; anything outside the eight divide ops is ignored.
  always_comb begin
    w_is_divop  = 1'b0;
    w_is_signed = 1'b0;
    w_is_rem    = 1'b0;
    w_is_w      = 1'b0;
    case (alufunc)
      ALU_DIV:   begin w_is_divop = 1'b1; w_is_signed = 1'b1; end
      ALU_DIVU:  begin w_is_divop = 1'b1; end
      ALU_REM:   begin w_is_divop = 1'b1; w_is_signed = 1'b1; w_is_rem = 1'b1; end
      ALU_REMU:  begin w_is_divop = 1'b1; w_is_rem = 1'b1; end
      ALU_DIVW:  begin w_is_divop = 1'b1; w_is_signed = 1'b1; w_is_w = 1'b1; end
      ALU_DIVUW: begin w_is_divop = 1'b1; w_is_w = 1'b1; end
      ALU_REMW:  begin w_is_divop = 1'b1; w_is_signed = 1'b1; w_is_rem = 1'b1; w_is_w = 1'b1; end
      ALU_REMUW: begin w_is_divop = 1'b1; w_is_rem = 1'b1; w_is_w = 1'b1; end
      default:   begin w_is_divop = 1'b0; end
    endcase
  end

  // Operand conditioning: width/sign interpretation, magnitudes and the special-case results.
  always_comb begin
    w_a32   = src1[31:0];
    w_b32   = src2[31:0];
    w_a_neg = w_is_signed & (w_is_w ? src1[31] : src1[63]);
    w_b_neg = w_is_signed & (w_is_w ? src2[31] : src2[63]);

    // W ops: signed forms sign-extend the low word, unsigned forms zero-extend it.
    if (w_is_w) begin
      w_a_ext = w_is_signed ? {{32{w_a32[31]}}, w_a32} : {32'b0, w_a32};
      w_b_ext = w_is_signed ? {{32{w_b32[31]}}, w_b32} : {32'b0, w_b32};
    end else begin
      w_a_ext = src1;
      w_b_ext = src2;
    end

    // Magnitudes; the most-negative value maps onto its unsigned magnitude naturally.
    w_a_abs = w_a_neg ? (~w_a_ext + 64'd1) : w_a_ext;
    w_b_abs = w_b_neg ? (~w_b_ext + 64'd1) : w_b_ext;

    // Dividend as seen by a W result: always sign-extended from bit 31, even for unsigned forms.
    w_a_sx = w_is_w ? {{32{w_a32[31]}}, w_a32} : src1;

    w_b_zero  = w_is_w ? (w_b32 == 32'd0) : (src2 == 64'd0);
    w_ovf     = w_is_signed &
                (w_is_w ? ((w_a32 == MIN32) && (w_b32 == 32'hFFFF_FFFF))
                        : ((src1 == MIN64) && (src2 == {64{1'b1}})));
    w_special = w_b_zero | w_ovf;

    if (w_b_zero) begin
      w_spec_res = w_is_rem ? w_a_sx : {64{1'b1}};
    end else begin
      w_spec_res = w_is_rem ? 64'd0 : w_a_sx;
    end
  end

  assign w_accept = (r_state == S_IDLE) & valid_in & w_is_divop & ~flush;

  // One restoring step: shift {rem,quo} left, subtract the divisor when it fits.
  always_comb begin
    w_rem_sh   = {r_rem, r_quo[63]};
    w_diff     = w_rem_sh - {1'b0, r_div};
    w_ge       = ~w_diff[64];
    w_rem_next = w_ge ? w_diff[63:0] : w_rem_sh[63:0];
    w_quo_next = {r_quo[62:0], w_ge};
    w_last_cnt = r_is_w ? 6'd31 : 6'd63;
  end

  // Final correction: apply signs, pick quotient or remainder, sign-extend W results.
  always_comb begin
    w_q_raw   = r_is_w ? {32'b0, r_quo[31:0]} : r_quo;
    w_q_fix   = r_neg_q ? (~w_q_raw + 64'd1) : w_q_raw;
    w_r_fix   = r_neg_r ? (~r_rem + 64'd1) : r_rem;
    w_sel     = r_is_rem ? w_r_fix : w_q_fix;
    w_fix_res = r_is_w ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
  end

  // Control FSM and iteration counter; reset and flush both abort to IDLE.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 6'd0;
          if (w_accept) begin
            r_state <= w_special ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == w_last_cnt) begin
            r_state <= S_FIX;
            r_cnt   <= 6'd0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_FIX:   r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers: load magnitudes at accept, then step once per BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem    <= 64'd0;
      r_quo    <= 64'd0;
      r_div    <= 64'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_is_w   <= 1'b0;
    end else if (w_accept) begin
      r_rem    <= 64'd0;
      // W dividends sit in the top half so 32 steps shift them fully into the remainder.
      r_quo    <= w_is_w ? {w_a_abs[31:0], 32'b0} : w_a_abs;
      r_div    <= w_b_abs;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_is_rem <= w_is_rem;
      r_is_w   <= w_is_w;
    end else if (r_state == S_BUSY && !flush) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
    end
  end

  // Result register: written for special cases at accept or from FIX; held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= 64'd0;
    end else if (!flush) begin
      if (w_accept && w_special) begin
        r_result <= w_spec_res;
      end else if (r_state == S_FIX) begin
        r_result <= w_fix_res;
      end
    end
  end

  assign ready  = (r_state == S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - randomized self-checking bench for div_iter_unit

module tb_div_iter_unit;
  import div_iter_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     flush;
  logic     valid_in;
  alufunc_t alufunc;
  word_t    src1;
  word_t    src2;
  logic     ready;
  logic     done;
  word_t    result;

  int n_total = 0;
  int n_bad   = 0;

  localparam word_t MIN64 = 64'h8000_0000_0000_0000;

  // 10 ns clock
  always #5 clk = ~clk;

  div_iter_unit u_dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .valid_in (valid_in),
    .alufunc  (alufunc),
    .src1     (src1),
    .src2     (src2),
    .ready    (ready),
    .done     (done),
    .result   (result)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic op_w(input alufunc_t f);
    return f inside {ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  endfunction

  function automatic logic op_signed(input alufunc_t f);
    return f inside {ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
  endfunction

  function automatic logic op_rem(input alufunc_t f);
    return f inside {ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};
  endfunction

  function automatic logic ref_special(input alufunc_t f, input word_t a, input word_t b);
    if (op_w(f))
      return (b[31:0] == 32'd0) ||
             (op_signed(f) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (op_signed(f) && a == MIN64 && b == {64{1'b1}});
  endfunction

  // RV64M semantics from plain arithmetic
  function automatic word_t ref_div(input alufunc_t f, input word_t a, input word_t b);
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] q32;
    logic [31:0] m32;
    word_t q;
    word_t m;
    a32 = a[31:0];
    b32 = b[31:0];
    if (!op_w(f)) begin
      if (b == 64'd0) begin
        q = {64{1'b1}};
        m = a;
      end else if (op_signed(f) && a == MIN64 && b == {64{1'b1}}) begin
        q = a;
        m = 64'd0;
      end else if (op_signed(f)) begin
        q = $signed(a) / $signed(b);
        m = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        m = a % b;
      end
      return op_rem(f) ? m : q;
    end
    if (b32 == 32'd0) begin
      q32 = 32'hFFFF_FFFF;
      m32 = a32;
    end else if (op_signed(f) && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
      q32 = a32;
      m32 = 32'd0;
    end else if (op_signed(f)) begin
      q32 = $signed(a32) / $signed(b32);
      m32 = $signed(a32) % $signed(b32);
    end else begin
      q32 = a32 / b32;
      m32 = a32 % b32;
    end
    return op_rem(f) ? {{32{m32[31]}}, m32} : {{32{q32[31]}}, q32};
  endfunction

  function automatic int ref_lat(input alufunc_t f, input word_t a, input word_t b);
    if (ref_special(f, a, b)) return 1;
    return op_w(f) ? 34 : 66;
  endfunction

  // Issue one op at a negedge, scramble operands after accept, measure latency and result.
  task automatic run_op(input string tag, input alufunc_t f, input word_t a, input word_t b,
                        input bit poke_busy);
    int    k;
    int    lat;
    word_t exp;
    exp = ref_div(f, a, b);
    lat = ref_lat(f, a, b);
    k = 0;
    while (!ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "/ready_pre"}, ready, 1'b1);
    valid_in = 1'b1;
    alufunc  = f;
    src1     = a;
    src2     = b;
    @(negedge clk);
    valid_in = 1'b0;
    src1     = {$urandom, $urandom};
    src2     = {$urandom, $urandom};
    k = 1;
    while (!done && k < 100) begin
      if (lat > 1 && k == 3) check_eq({tag, "/busy_ready"}, ready, 1'b0);
      valid_in = (poke_busy && k == 5);
      alufunc  = ALU_DIVU;
      @(negedge clk);
      valid_in = 1'b0;
      k++;
    end
    check_eq({tag, "/latency"}, 64'(k), 64'(lat));
    check_eq({tag, "/result"}, result, exp);
    @(negedge clk);
    check_eq({tag, "/done_low"}, done, 1'b0);
    check_eq({tag, "/ready_post"}, ready, 1'b1);
  endtask

  initial begin
    int       n_done;
    alufunc_t ops[8];
    alufunc_t f;
    word_t    a;
    word_t    b;
    ops = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};

    reset    = 1'b1;
    flush    = 1'b0;
    valid_in = 1'b0;
    alufunc  = ALU_ADD;
    src1     = 64'd0;
    src2     = 64'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst/ready", ready, 1'b1);
    check_eq("rst/done", done, 1'b0);
    check_eq("rst/result", result, 64'd0);

    run_op("divu100_7", ALU_DIVU, 64'd100, 64'd7, 1'b0);
    run_op("remu100_7", ALU_REMU, 64'd100, 64'd7, 1'b0);
    check_eq("remu100_7/abs", result, 64'd2);
    run_op("divw_m7_2", ALU_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b0);
    check_eq("divw_m7_2/abs", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem_m7_2", ALU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0);
    check_eq("rem_m7_2/abs", result, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div_by0", ALU_DIV, 64'd5, 64'd0, 1'b0);
    run_op("remuw_by0", ALU_REMUW, 64'h1_8000_0000, 64'd0, 1'b0);
    check_eq("remuw_by0/abs", result, 64'hFFFF_FFFF_8000_0000);
    run_op("div_ovf", ALU_DIV, MIN64, {64{1'b1}}, 1'b0);
    run_op("remw_ovf", ALU_REMW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0);
    check_eq("remw_ovf/abs", result, 64'd0);

    // Non-divide request must be ignored
    valid_in = 1'b1;
    alufunc  = ALU_ADD;
    src1     = 64'd4;
    src2     = 64'd2;
    @(negedge clk);
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("nondiv/ready", ready, 1'b1);
      check_eq("nondiv/done", done, 1'b0);
      @(negedge clk);
    end

    // Flush mid-operation, then an immediate new op
    valid_in = 1'b1;
    alufunc  = ALU_DIVU;
    src1     = 64'd100;
    src2     = 64'd7;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("flush/done_before", done, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush/ready", ready, 1'b1);
    check_eq("flush/done", done, 1'b0);
    run_op("after_flush", ALU_DIVU, 64'd9, 64'd3, 1'b0);

    // Flush together with valid in IDLE: nothing accepted
    valid_in = 1'b1;
    flush    = 1'b1;
    alufunc  = ALU_DIVU;
    src1     = 64'd5;
    src2     = 64'd1;
    @(negedge clk);
    valid_in = 1'b0;
    flush    = 1'b0;
    check_eq("flush_valid/ready", ready, 1'b1);
    @(negedge clk);
    check_eq("flush_valid/done", done, 1'b0);

    // valid_in pulsed while busy, then back-to-back ops
    run_op("poke_busy", ALU_DIVU, 64'd1000, 64'd10, 1'b1);
    run_op("b2b_second", ALU_DIVU, 64'd81, 64'd9, 1'b0);
    check_eq("b2b_second/abs", result, 64'd9);

    // Reset mid-BUSY clears result and produces no done
    valid_in = 1'b1;
    alufunc  = ALU_DIVU;
    src1     = 64'd100;
    src2     = 64'd7;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_busy/result", result, 64'd0);
    check_eq("rst_busy/ready", ready, 1'b1);
    n_done = 0;
    for (int i = 0; i < 70; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check_eq("rst_busy/no_done", 64'(n_done), 64'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 7)];
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 50)); end
        1: b = 64'd0;
        2: begin a = MIN64; b = {64{1'b1}}; end
        3: begin a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hFFFF_FFFF}; end
        4: b = {{32{1'b1}}, $urandom} >> $urandom_range(0, 40);
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), f, a, b, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
